// File: rtl/rv_pkg.sv
// -----------------------------------------------------------------------------
// rv_pkg
// Shared register-file geometry and the write-back source selector used by the
// write-back controller and its scoreboard.
//   XLEN       : data width of a register
//   REG_ADDR_W : width of a register index
//   NUM_REGS   : number of architectural registers (x0 hard-wired to zero)
//   wb_src_e   : which producer owns the write port in a given cycle
// -----------------------------------------------------------------------------
package rv_pkg;

   localparam int XLEN       = 32;
   localparam int REG_ADDR_W = 5;
   localparam int NUM_REGS   = 32;

   typedef enum logic [1:0] {
      WB_NONE,
      WB_ALU,
      WB_LD
   } wb_src_e;

endpackage

// File: rtl/wb_scoreboard.sv
// -----------------------------------------------------------------------------
// wb_scoreboard
// Tracks which registers have a write outstanding and flags issue hazards.
// A register becomes busy when an instruction writing it issues cleanly and
// becomes free when its result leaves the registered write port.
//
// Ports
//   clk, rst_n         : clock, asynchronous active-low reset
//   iss_valid/iss_rd   : instruction issue and its destination
//   iss_rs1/iss_rs2    : source registers of the issuing instruction
//   wb_en/wb_addr      : registered write port of the register file
//   busy               : one bit per register, bit 0 always 0
//   hazard             : issue must stall this cycle
//
// Build option
//   WB_FWD_EN : a source matching the register being written this cycle is
//               not a hazard, because the register file writes through.
// -----------------------------------------------------------------------------
module wb_scoreboard
   import rv_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  iss_valid,
   input  logic [REG_ADDR_W-1:0] iss_rd,
   input  logic [REG_ADDR_W-1:0] iss_rs1,
   input  logic [REG_ADDR_W-1:0] iss_rs2,
   input  logic                  wb_en,
   input  logic [REG_ADDR_W-1:0] wb_addr,
   output logic [NUM_REGS-1:0]   busy,
   output logic                  hazard
);

   logic [NUM_REGS-1:0] busy_q;
   logic [NUM_REGS-1:0] busy_d;
   logic [NUM_REGS-1:0] set_mask;
   logic [NUM_REGS-1:0] clr_mask;
   logic                rs1_busy;
   logic                rs2_busy;
   logic                rd_busy;
   logic                issue_ok;

   always_comb begin
      rs1_busy = busy_q[iss_rs1];
      rs2_busy = busy_q[iss_rs2];
      rd_busy  = busy_q[iss_rd];
`ifdef WB_FWD_EN
      // Only sources can be forwarded; a pending write to the destination
      // is still a WAW hazard.
      if (wb_en && (iss_rs1 == wb_addr)) rs1_busy = 1'b0;
      if (wb_en && (iss_rs2 == wb_addr)) rs2_busy = 1'b0;
`endif
   end

   // Held low during reset even if the issue inputs are active.
   assign hazard   = rst_n & iss_valid & (rs1_busy | rs2_busy | rd_busy);
   assign issue_ok = iss_valid & ~hazard & (iss_rd != '0);

   always_comb begin
      set_mask = '0;
      clr_mask = '0;
      if (issue_ok) set_mask = NUM_REGS'(1) << iss_rd;
      if (wb_en)    clr_mask = NUM_REGS'(1) << wb_addr;
      // Set after clear: a same-cycle re-issue of the retiring register wins.
      busy_d    = (busy_q & ~clr_mask) | set_mask;
      busy_d[0] = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) busy_q <= '0;
      else        busy_q <= busy_d;
   end

   assign busy = busy_q;

endmodule

// File: rtl/reg_wb_ctrl.sv
// -----------------------------------------------------------------------------
// reg_wb_ctrl
// Write-back controller: arbitrates a single-cycle ALU result and a held load
// result onto one registered register-file write port, with a starvation
// guard for the load, and keeps the register scoreboard.
//
// Ports
//   clk_in, rst_n_in                       : clock, async active-low reset
//   iss_valid_in, iss_rd_in                : issue of an rd-writing instruction
//   iss_rs1_in, iss_rs2_in                 : its source registers
//   alu_valid_in, alu_rd_in, alu_data_in   : ALU result
//   ld_valid_in, ld_rd_in, ld_data_in      : load result, held until accepted
//   ld_ready_o                             : load accepted this cycle
//   alu_stall_o                            : ALU must hold its result
//   wr_en_o, rd_addr_o, rd_data_o          : registered write port
//   busy_o, hazard_o                       : scoreboard vector, issue stall
//
// Parameter
//   STARVE_LIMIT : cycles a pending load may lose before it is forced through
// Build option
//   WB_FWD_EN    : hazard check assumes register-file write-through
// -----------------------------------------------------------------------------
module reg_wb_ctrl
   import rv_pkg::*;
#(
   parameter int STARVE_LIMIT = 4
) (
   input  logic                  clk_in,
   input  logic                  rst_n_in,
   input  logic                  iss_valid_in,
   input  logic [REG_ADDR_W-1:0] iss_rd_in,
   input  logic [REG_ADDR_W-1:0] iss_rs1_in,
   input  logic [REG_ADDR_W-1:0] iss_rs2_in,
   input  logic                  alu_valid_in,
   input  logic [REG_ADDR_W-1:0] alu_rd_in,
   input  logic [XLEN-1:0]       alu_data_in,
   input  logic                  ld_valid_in,
   input  logic [REG_ADDR_W-1:0] ld_rd_in,
   input  logic [XLEN-1:0]       ld_data_in,
   output logic                  ld_ready_o,
   output logic                  alu_stall_o,
   output logic                  wr_en_o,
   output logic [REG_ADDR_W-1:0] rd_addr_o,
   output logic [XLEN-1:0]       rd_data_o,
   output logic [NUM_REGS-1:0]   busy_o,
   output logic                  hazard_o
);

   // The counter never passes STARVE_LIMIT: reaching it forces a grant.
   localparam int CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

   logic [CNT_W-1:0]      starve_cnt;
   logic                  force_ld;
   wb_src_e               grant_src;
   logic [REG_ADDR_W-1:0] sel_rd;
   logic [XLEN-1:0]       sel_data;

   logic                  wr_en_p1;
   logic [REG_ADDR_W-1:0] rd_addr_p1;
   logic [XLEN-1:0]       rd_data_p1;

   // Arbitration: ALU by default, load when the ALU is idle or starved too long.
   always_comb begin
      force_ld  = ld_valid_in && (starve_cnt == CNT_W'(STARVE_LIMIT));
      grant_src = WB_NONE;
      if (force_ld)          grant_src = WB_LD;
      else if (alu_valid_in) grant_src = WB_ALU;
      else if (ld_valid_in)  grant_src = WB_LD;

      sel_rd   = '0;
      sel_data = '0;
      case (grant_src)
         WB_ALU: begin
            sel_rd   = alu_rd_in;
            sel_data = alu_data_in;
         end
         WB_LD: begin
            sel_rd   = ld_rd_in;
            sel_data = ld_data_in;
         end
         default: ;
      endcase
   end

   assign ld_ready_o  = rst_n_in && (grant_src == WB_LD);
   assign alu_stall_o = rst_n_in && force_ld;

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         starve_cnt <= '0;
      end else if (ld_valid_in && (grant_src != WB_LD)) begin
         starve_cnt <= starve_cnt + CNT_W'(1);
      end else begin
         starve_cnt <= '0;
      end
   end

   // ---- stage p1: registered write port ----
   // A result for x0 is consumed but never written.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         wr_en_p1   <= 1'b0;
         rd_addr_p1 <= '0;
         rd_data_p1 <= '0;
      end else begin
         wr_en_p1 <= (grant_src != WB_NONE) && (sel_rd != '0);
         if (grant_src != WB_NONE) begin
            rd_addr_p1 <= sel_rd;
            rd_data_p1 <= sel_data;
         end
      end
   end

   assign wr_en_o   = wr_en_p1;
   assign rd_addr_o = rd_addr_p1;
   assign rd_data_o = rd_data_p1;

   wb_scoreboard u_scoreboard (
      .clk       (clk_in),
      .rst_n     (rst_n_in),
      .iss_valid (iss_valid_in),
      .iss_rd    (iss_rd_in),
      .iss_rs1   (iss_rs1_in),
      .iss_rs2   (iss_rs2_in),
      .wb_en     (wr_en_p1),
      .wb_addr   (rd_addr_p1),
      .busy      (busy_o),
      .hazard    (hazard_o)
   );

endmodule

// File: tb/tb_reg_wb_ctrl.sv
// -----------------------------------------------------------------------------
// tb_reg_wb_ctrl
// Directed scenarios with literal expectations, then randomized traffic,
// all compared every cycle against a behavioural model of the write-back
// controller. Honours WB_FWD_EN when it is defined for the build.
// -----------------------------------------------------------------------------
module tb_reg_wb_ctrl;

   localparam int LIMIT = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        iss_valid;
   logic [4:0]  iss_rd, iss_rs1, iss_rs2;
   logic        alu_valid;
   logic [4:0]  alu_rd;
   logic [31:0] alu_data;
   logic        ld_valid;
   logic [4:0]  ld_rd;
   logic [31:0] ld_data;
   logic        ld_ready, alu_stall, wr_en, hazard;
   logic [4:0]  rd_addr;
   logic [31:0] rd_data, busy;

   always #5 clk = ~clk;

   reg_wb_ctrl #(.STARVE_LIMIT(LIMIT)) dut (
      .clk_in       (clk),
      .rst_n_in     (rst_n),
      .iss_valid_in (iss_valid),
      .iss_rd_in    (iss_rd),
      .iss_rs1_in   (iss_rs1),
      .iss_rs2_in   (iss_rs2),
      .alu_valid_in (alu_valid),
      .alu_rd_in    (alu_rd),
      .alu_data_in  (alu_data),
      .ld_valid_in  (ld_valid),
      .ld_rd_in     (ld_rd),
      .ld_data_in   (ld_data),
      .ld_ready_o   (ld_ready),
      .alu_stall_o  (alu_stall),
      .wr_en_o      (wr_en),
      .rd_addr_o    (rd_addr),
      .rd_data_o    (rd_data),
      .busy_o       (busy),
      .hazard_o     (hazard)
   );

   int errors = 0;
   int checks = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   bit          chk_en = 1'b0;
   bit          m_busy [32];
   int          m_wait;          // cycles the current load has lost so far
   bit          m_wr_en;
   logic [4:0]  m_addr;
   logic [31:0] m_data;
   bit          m_acc_alu, m_acc_ld;

   task automatic model_reset();
      foreach (m_busy[i]) m_busy[i] = 1'b0;
      m_wait    = 0;
      m_wr_en   = 1'b0;
      m_addr    = '0;
      m_data    = '0;
      m_acc_alu = 1'b0;
      m_acc_ld  = 1'b0;
   endtask

   always @(negedge clk) begin : compare
      bit          starved, g_ld, g_alu, s1, s2, hz;
      logic [31:0] bv;
      if (chk_en) begin
         starved = ld_valid && (m_wait == LIMIT);
         g_ld    = ld_valid && (!alu_valid || starved);
         g_alu   = alu_valid && !starved;
         s1 = m_busy[iss_rs1];
         s2 = m_busy[iss_rs2];
`ifdef WB_FWD_EN
         if (m_wr_en && iss_rs1 == m_addr) s1 = 1'b0;
         if (m_wr_en && iss_rs2 == m_addr) s2 = 1'b0;
`endif
         hz = iss_valid && (s1 || s2 || m_busy[iss_rd]);
         bv = '0;
         for (int i = 1; i < 32; i++) bv[i] = m_busy[i];

         check("ld_ready", {31'd0, ld_ready}, {31'd0, g_ld});
         check("alu_stall", {31'd0, alu_stall}, {31'd0, starved});
         check("hazard", {31'd0, hazard}, {31'd0, hz});
         check("wr_en", {31'd0, wr_en}, {31'd0, m_wr_en});
         check("busy", busy, bv);
         if (m_wr_en) begin
            check("rd_addr", {27'd0, rd_addr}, {27'd0, m_addr});
            check("rd_data", rd_data, m_data);
         end

         if (m_wr_en) m_busy[m_addr] = 1'b0;
         if (iss_valid && !hz && iss_rd != 0) m_busy[iss_rd] = 1'b1;
         if (g_alu) begin
            m_wr_en = (alu_rd != 0); m_addr = alu_rd; m_data = alu_data;
         end else if (g_ld) begin
            m_wr_en = (ld_rd != 0);  m_addr = ld_rd;  m_data = ld_data;
         end else begin
            m_wr_en = 1'b0;
         end
         m_wait    = (ld_valid && !g_ld) ? m_wait + 1 : 0;
         m_acc_alu = g_alu;
         m_acc_ld  = g_ld;
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      iss_valid = 0; iss_rd = 0; iss_rs1 = 0; iss_rs2 = 0;
      alu_valid = 0; alu_rd = 0; alu_data = 0;
      ld_valid  = 0; ld_rd  = 0; ld_data  = 0;
   endtask

   task automatic issue(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
      iss_valid = 1; iss_rd = rd; iss_rs1 = rs1; iss_rs2 = rs2;
   endtask

   initial begin : watchdog
      #500000;
      errors++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin : main
      idle();
      rst_n = 1'b0;
      model_reset();

      // Reset: combinational outputs held low even with live inputs.
      #3;
      ld_valid = 1; issue(5'd3, 5'd1, 5'd2);
      #1;
      check("rst_ld_ready", {31'd0, ld_ready}, 32'd0);
      check("rst_alu_stall", {31'd0, alu_stall}, 32'd0);
      check("rst_hazard", {31'd0, hazard}, 32'd0);
      check("rst_wr_en", {31'd0, wr_en}, 32'd0);
      check("rst_busy", busy, 32'd0);
      check("rst_rd_data", rd_data, 32'd0);
      idle();
      @(posedge clk); #2;
      rst_n = 1'b1; model_reset(); chk_en = 1'b1;

      // ALU result lands one cycle later.
      cyc(); alu_valid = 1; alu_rd = 5; alu_data = 32'hDEADBEEF;
      cyc(); alu_valid = 0;
      @(negedge clk);
      check("alu_wr_en", {31'd0, wr_en}, 32'd1);
      check("alu_rd_addr", {27'd0, rd_addr}, 32'd5);
      check("alu_rd_data", rd_data, 32'hDEADBEEF);
      cyc();
      @(negedge clk);
      check("alu_wr_en_drop", {31'd0, wr_en}, 32'd0);

      // RAW hazard on x7 until its write retires.
      cyc(); issue(5'd7, 5'd0, 5'd0);
      @(negedge clk);
      check("raw_first_issue", {31'd0, hazard}, 32'd0);
      cyc(); issue(5'd8, 5'd7, 5'd0);
      @(negedge clk);
      check("raw_hazard", {31'd0, hazard}, 32'd1);
      check("raw_busy7", {31'd0, busy[7]}, 32'd1);
      cyc(); alu_valid = 1; alu_rd = 7; alu_data = 32'h77;
      @(negedge clk);
      check("raw_hazard_alu", {31'd0, hazard}, 32'd1);
      cyc(); alu_valid = 0;
      @(negedge clk);
      check("raw_wr7", {31'd0, wr_en}, 32'd1);
`ifdef WB_FWD_EN
      check("raw_hazard_fwd", {31'd0, hazard}, 32'd0);
`else
      check("raw_hazard_wr", {31'd0, hazard}, 32'd1);
`endif
      cyc();
      @(negedge clk);
      check("raw_busy7_clr", {31'd0, busy[7]}, 32'd0);
`ifdef WB_FWD_EN
      check("raw_waw8", {31'd0, hazard}, 32'd1);
`else
      check("raw_hazard_clr", {31'd0, hazard}, 32'd0);
`endif
      cyc(); idle(); alu_valid = 1; alu_rd = 8; alu_data = 32'h88;
      cyc(); idle();

      // Load starved by a continuous ALU stream is forced on the 5th cycle.
      cyc(); alu_valid = 1; alu_rd = 1; alu_data = $urandom;
      ld_valid = 1; ld_rd = 2; ld_data = 32'h11112222;
      for (int k = 1; k <= 5; k++) begin
         @(negedge clk);
         check($sformatf("starve_ready_%0d", k), {31'd0, ld_ready}, {31'd0, (k == 5)});
         check($sformatf("starve_stall_%0d", k), {31'd0, alu_stall}, {31'd0, (k == 5)});
         cyc();
         if (m_acc_alu) alu_data = $urandom;
         if (m_acc_ld) ld_valid = 0;
      end
      @(negedge clk);
      check("starve_wr_addr", {27'd0, rd_addr}, 32'd2);
      check("starve_wr_data", rd_data, 32'h11112222);
      cyc(); idle();

      // ALU and load to x3 in the same cycle: two ordered writes.
      cyc(); issue(5'd3, 5'd0, 5'd0);
      cyc(); idle();
      alu_valid = 1; alu_rd = 3; alu_data = 32'hAAAA0003;
      ld_valid  = 1; ld_rd  = 3; ld_data  = 32'hBBBB0003;
      @(negedge clk);
      check("same_rd_ld_wait", {31'd0, ld_ready}, 32'd0);
      check("same_rd_busy3", {31'd0, busy[3]}, 32'd1);
      cyc(); alu_valid = 0;
      @(negedge clk);
      check("same_rd_ld_go", {31'd0, ld_ready}, 32'd1);
      check("same_rd_first", rd_data, 32'hAAAA0003);
      cyc(); ld_valid = 0;
      @(negedge clk);
      check("same_rd_second_en", {31'd0, wr_en}, 32'd1);
      check("same_rd_second", rd_data, 32'hBBBB0003);
      cyc();
      @(negedge clk);
      check("same_rd_busy3_clr", {31'd0, busy[3]}, 32'd0);

      // Results and issues for x0 never write or mark busy.
      cyc(); alu_valid = 1; alu_rd = 0; alu_data = 32'h1234; issue(5'd0, 5'd0, 5'd0);
      cyc(); idle();
      @(negedge clk);
      check("x0_wr_en", {31'd0, wr_en}, 32'd0);
      check("x0_busy", {31'd0, busy[0]}, 32'd0);

      // Reset while a load is waiting, then counter restarts from zero.
      for (int r = 4; r <= 7; r++) begin
         cyc(); issue(5'(r), 5'd0, 5'd0);
      end
      cyc(); idle();
      alu_valid = 1; alu_rd = 9;  alu_data = 32'hC0C0C0C0;
      ld_valid  = 1; ld_rd  = 10; ld_data  = 32'hD0D0D0D0;
      @(negedge clk);
      check("pre_rst_busy", busy, 32'h000000F0);
      cyc();
      @(negedge clk);
      check("pre_rst_ld_wait", {31'd0, ld_ready}, 32'd0);
      #2;
      chk_en = 1'b0;
      rst_n  = 1'b0;
      issue(5'd11, 5'd4, 5'd5);
      #1;
      check("mid_rst_busy", busy, 32'd0);
      check("mid_rst_wr_en", {31'd0, wr_en}, 32'd0);
      check("mid_rst_rd_addr", {27'd0, rd_addr}, 32'd0);
      check("mid_rst_rd_data", rd_data, 32'd0);
      check("mid_rst_ld_ready", {31'd0, ld_ready}, 32'd0);
      check("mid_rst_alu_stall", {31'd0, alu_stall}, 32'd0);
      check("mid_rst_hazard", {31'd0, hazard}, 32'd0);
      iss_valid = 0;
      @(posedge clk); #2;
      rst_n = 1'b1; model_reset(); chk_en = 1'b1;
      for (int k = 1; k <= 5; k++) begin
         @(negedge clk);
         check($sformatf("post_rst_ready_%0d", k), {31'd0, ld_ready}, {31'd0, (k == 5)});
         cyc();
         if (m_acc_ld) ld_valid = 0;
      end
      idle();

      // Randomized traffic with producers honouring hold-until-accepted.
      for (int i = 0; i < 3000; i++) begin
         if (i == 1500) begin
            @(negedge clk); #2;
            chk_en = 1'b0;
            rst_n  = 1'b0;
            #1;
            check("rand_rst_busy", busy, 32'd0);
            check("rand_rst_wr_en", {31'd0, wr_en}, 32'd0);
            @(posedge clk); #2;
            rst_n = 1'b1; model_reset(); chk_en = 1'b1;
         end
         cyc();
         if (!alu_valid || m_acc_alu) begin
            alu_valid = ($urandom_range(0, 3) != 0);
            alu_rd    = 5'($urandom_range(0, 9));
            alu_data  = $urandom;
         end
         if (!ld_valid || m_acc_ld) begin
            ld_valid = ($urandom_range(0, 2) == 0);
            ld_rd    = 5'($urandom_range(0, 9));
            ld_data  = $urandom;
         end
         iss_valid = ($urandom_range(0, 1) == 1);
         iss_rd    = 5'($urandom_range(0, 9));
         iss_rs1   = 5'($urandom_range(0, 9));
         iss_rs2   = 5'($urandom_range(0, 9));
      end
      @(negedge clk);
      chk_en = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
